// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: default widths and FSM state encoding.
package alu_seq_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned N_OPS  = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ISSUE   = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } seq_state_t;

endpackage

// File: rtl/seq_result_bank.sv
// Result bank for the ALU op sequencer: N_OPS result words plus per-op carry/zero
// flags, single write port, async clear, combinational read.
module seq_result_bank
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = alu_seq_pkg::DATA_W,
   parameter int unsigned OP_W   = alu_seq_pkg::OP_W,
   parameter int unsigned N_OPS  = alu_seq_pkg::N_OPS
) (
   input  logic              clk,
   input  logic              RSTN,
   input  logic              we,
   input  logic [OP_W-1:0]   wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_co,
   input  logic              wr_zero,
   input  logic [OP_W-1:0]   rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic [N_OPS-1:0]  co_flags,
   output logic [N_OPS-1:0]  zero_flags
);

   logic [DATA_W-1:0] mem [N_OPS];

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         for (int unsigned i = 0; i < N_OPS; i++) mem[i] <= '0;
         co_flags   <= '0;
         zero_flags <= '0;
      end else if (we) begin
         mem[wr_idx]        <= wr_data;
         co_flags[wr_idx]   <= wr_co;
         zero_flags[wr_idx] <= wr_zero;
      end
   end

   // Widened compare so the range check still works when N_OPS == 2**OP_W.
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_sel} < (OP_W+1)'(N_OPS)) rd_data = mem[rd_sel];
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sweeps the shared ALU through op codes 0..N_OPS-1 on a snapshot of A/B and banks results.
// Optional macro SEQ_SINGLE_STEP_EN adds a 'step' input gating each ISSUE -> CAPTURE move.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = alu_seq_pkg::DATA_W,
   parameter int unsigned OP_W   = alu_seq_pkg::OP_W,
   parameter int unsigned N_OPS  = alu_seq_pkg::N_OPS
) (
   input  logic              clk,
   input  logic              RSTN,
   input  logic              start,
   input  logic              abort,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic              step,
`endif
   input  logic [DATA_W-1:0] A_in,
   input  logic [DATA_W-1:0] B_in,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_co,
   input  logic              alu_zero,
   output logic [DATA_W-1:0] alu_A,
   output logic [DATA_W-1:0] alu_B,
   output logic [OP_W-1:0]   ALU_Ctr,
   output logic              busy,
   output logic              done,
   input  logic [OP_W-1:0]   res_sel,
   output logic [DATA_W-1:0] res_out,
   output logic [N_OPS-1:0]  co_flags,
   output logic [N_OPS-1:0]  zero_flags
);

   localparam logic [OP_W-1:0] LAST_OP = OP_W'(N_OPS - 1);

   seq_state_t      state, state_nxt;
   logic [OP_W-1:0] op;
   logic            issue_go;

`ifdef SEQ_SINGLE_STEP_EN
   assign issue_go = step;
`else
   assign issue_go = 1'b1;
`endif

   // State register plus the datapath registers that move with it.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state   <= S_IDLE;
         op      <= '0;
         alu_A   <= '0;
         alu_B   <= '0;
         ALU_Ctr <= '0;
      end else begin
         state <= state_nxt;
         if (abort) begin
            op <= '0;
         end else begin
            case (state)
               S_LOAD: begin
                  alu_A   <= A_in;
                  alu_B   <= B_in;
                  op      <= '0;
                  ALU_Ctr <= '0;
               end
               // ALU_Ctr is loaded alongside op so it is already valid on entry to ISSUE.
               S_CAPTURE: begin
                  if (op != LAST_OP) begin
                     op      <= op + 1'b1;
                     ALU_Ctr <= op + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_ISSUE;
            S_ISSUE:   if (issue_go) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = (op == LAST_OP) ? S_DONE : S_ISSUE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_LOAD, S_ISSUE, S_CAPTURE: busy = 1'b1;
         S_DONE:                     done = 1'b1;
         default: ;
      endcase
   end

   // A capture cycle always commits, even when abort is raised in it.
   seq_result_bank #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W),
      .N_OPS  (N_OPS)
   ) u_bank (
      .clk        (clk),
      .RSTN       (RSTN),
      .we         (state == S_CAPTURE),
      .wr_idx     (op),
      .wr_data    (alu_res),
      .wr_co      (alu_co),
      .wr_zero    (alu_zero),
      .rd_sel     (res_sel),
      .rd_data    (res_out),
      .co_flags   (co_flags),
      .zero_flags (zero_flags)
   );

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences the shared 32-bit ALU through every ALU_Ctr operation code for one snapshot of operands Ai/Bi.
- Captures each result, carry-out and zero flag into a result bank, which a display select port reads.
- Sits between the SEnter operand entry and the ALU; the result read port feeds a Multi_8CH32 test channel.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 3, ALU_Ctr width
- N_OPS, 8, number of ops sequenced, codes 0..N_OPS-1, N_OPS <= 2**OP_W

Ports:
- clk  in  1  system clock
- RSTN  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse (BTN_OK-derived); begins a sweep
- abort  in  1  level; returns FSM to IDLE
- A_in  in  DATA_W  operand A from entry block
- B_in  in  DATA_W  operand B
- alu_res  in  DATA_W  ALU result (combinational from alu_A/alu_B/ALU_Ctr)
- alu_co  in  1  ALU carry-out
- alu_zero  in  1  ALU zero flag
- alu_A  out  DATA_W  latched operand A to ALU
- alu_B  out  DATA_W  latched operand B to ALU
- ALU_Ctr  out  OP_W  current op code
- busy  out  1  high in LOAD/ISSUE/CAPTURE
- done  out  1  one-cycle pulse at sweep end
- res_sel  in  OP_W  bank read index
- res_out  out  DATA_W  bank[res_sel], combinational read
- co_flags  out  N_OPS  bit k = carry of op k
- zero_flags  out  N_OPS  bit k = zero of op k

Behaviour:
- Reset (RSTN=0, async): state IDLE, op=0, alu_A=alu_B=0, ALU_Ctr=0, busy=0, done=0, all bank entries and flags 0.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD: alu_A<=A_in, alu_B<=B_in, op<=0 -> ISSUE.
  - ISSUE: ALU_Ctr=op; the ALU settles -> CAPTURE.
  - CAPTURE: bank[op]<=alu_res, co_flags[op]<=alu_co, zero_flags[op]<=alu_zero. If op==N_OPS-1 -> DONE, else op<=op+1 -> ISSUE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Timing: start sampled in cycle 0 -> LOAD in cycle 1 -> first ISSUE in cycle 2 -> last CAPTURE in cycle 1+2*N_OPS -> done high in cycle 2+2*N_OPS (cycle 18 at defaults).
- ALU_Ctr is a registered output: it holds op during ISSUE and CAPTURE, and holds its last value in IDLE/DONE.
- Operands are snapshotted in LOAD. Changes on A_in/B_in mid-sweep are ignored.
- start while busy or in DONE is ignored, with no queuing.
- abort has priority over every transition. Any state -> IDLE next cycle, done not asserted, entries already captured are kept, op<=0.
- start and abort high together in IDLE: abort wins, stay IDLE.
- The bank keeps its contents until the next sweep overwrites it entry by entry.
- res_sel >= N_OPS: res_out=0.
- Async reset mid-sweep clears everything immediately. There is no resume.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (one-cycle pulse).
  - ISSUE waits in place until step=1, then -> CAPTURE. This lets the user walk through ops on the 7-seg display.
  - abort still exits immediately.
- When undefined:
  - The step port is absent.
  - ISSUE -> CAPTURE unconditionally, with the timing above.

Decomposition:
- Shared package alu_seq_pkg holds:
  - state encoding constants S_IDLE, S_LOAD, S_ISSUE, S_CAPTURE, S_DONE (3-bit)
  - default widths DATA_W/OP_W/N_OPS
- One sub-module, seq_result_bank: N_OPS x DATA_W register file plus flag vectors, with a write port (we, index, data, co, zero), async clear on RSTN, and a combinational read.
- The FSM stays in alu_op_sequencer.

Test Plan:
- Bench ALU model: res = A + k*B for op k, co = bit 32 of that sum, zero = (res==0).
- Full sweep: A_in=5, B_in=3, start pulse at cycle 0 -> done pulse in cycle 18; res_sel=k gives 5+3k (k=7 -> 26); co_flags=0, zero_flags=0.
- Overflow/zero: A_in=0xFFFFFFFF, B_in=1 -> bank[1]=0, co_flags[1]=1, zero_flags[1]=1; bank[0]=0xFFFFFFFF, co_flags[0]=0.
- Abort mid-sweep: after the full-sweep run, start again with A_in=10, B_in=3, then abort at cycle 7 (first 3 captures done) -> IDLE next cycle, no done; bank[0..2]=10,13,16; bank[3..7] still hold the previous sweep (14,17,20,23,26).
- Start while busy and operand change: restart with A_in=5, B_in=3, then second start at cycle 5 and A_in changed to 99 at cycle 6 -> ignored; single done at cycle 18; all results use A=5.
- Reset mid-sweep: RSTN low at cycle 9 -> same cycle busy=0, ALU_Ctr=0, all res_out=0, flags 0. With SEQ_SINGLE_STEP_EN, the sweep holds in ISSUE with ALU_Ctr=0 until a step pulse; 8 steps -> done.
